inv_round_tail: RTL and testbench

Column-serial AES decryption round tail. Sits directly downstream of `InvSubBytes` and accepts its 128-bit output state. Each block is XORed with the round key (AddRoundKey) and then passed through InvMixColumns one column group per cycle; for the final round, InvMixColumns is bypassed. It replaces a flat combinational AddRoundKey + InvMixColumns path with a registered, handshaked stage.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/inv_mix_column.sv | 22 ++
 rtl/inv_round_tail.sv | 87 ++++++++
 tb/tb_inv_round_tail.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multipliers, the 128-bit state type
// and the round-tail FSM encoding.
package aes_pkg;

    localparam logic [7:0]  AES_POLY  = 8'h1B;
    localparam int unsigned AES_BITS  = 128;
    localparam int unsigned COL_BITS  = 32;
    localparam int unsigned NUM_COLS  = 4;

    typedef logic [AES_BITS-1:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } tail_state_t;

    // Multiply by x modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] gf_mulB(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] gf_mulD(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] gf_mulE(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns for a single column; byte r of the column is
// i_col[8r+7:8r].
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [COL_BITS-1:0] i_col,
    output logic [COL_BITS-1:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[7:0];
    assign w_a1 = i_col[15:8];
    assign w_a2 = i_col[23:16];
    assign w_a3 = i_col[31:24];

    assign o_col[7:0]   = gf_mulE(w_a0) ^ gf_mulB(w_a1) ^ gf_mulD(w_a2) ^ gf_mul9(w_a3);
    assign o_col[15:8]  = gf_mul9(w_a0) ^ gf_mulE(w_a1) ^ gf_mulB(w_a2) ^ gf_mulD(w_a3);
    assign o_col[23:16] = gf_mulD(w_a0) ^ gf_mul9(w_a1) ^ gf_mulE(w_a2) ^ gf_mulB(w_a3);
    assign o_col[31:24] = gf_mulB(w_a0) ^ gf_mulD(w_a1) ^ gf_mul9(w_a2) ^ gf_mulE(w_a3);

endmodule

// File: rtl/inv_round_tail.sv
// AES decryption round tail: AddRoundKey on accept, then InvMixColumns
// applied COLS_PER_CYCLE columns per cycle (bypassed for the final round).
module inv_round_tail
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AES_BITS-1:0] instate,
    input  logic [AES_BITS-1:0] round_key,
    input  logic                skip_mix,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [AES_BITS-1:0] outstate
);

    // Column index of the last group, and the per-cycle counter step (4 wraps to 0)
    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    tail_state_t   r_state;
    aes_state_t    r_st;
    logic [1:0]    r_col;

    logic [1:0]          w_sel    [COLS_PER_CYCLE];
    logic [COL_BITS-1:0] w_col_in [COLS_PER_CYCLE];
    logic [COL_BITS-1:0] w_col_out[COLS_PER_CYCLE];

    // Column mux: pick the group starting at r_col out of the state register
    always_comb begin
        for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
            w_sel[g]    = r_col + 2'(g);
            w_col_in[g] = r_st[{w_sel[g], 5'd0} +: COL_BITS];
        end
    end

    for (genvar g = 0; g < int'(COLS_PER_CYCLE); g++) begin : g_imc
        inv_mix_column u_imc (
            .i_col (w_col_in[g]),
            .o_col (w_col_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_st    <= '0;
            r_col   <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_st    <= instate ^ round_key;
                        r_col   <= 2'd0;
                        r_state <= skip_mix ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Column demux: write the transformed group back in place
                    for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
                        r_st[{w_sel[g], 5'd0} +: COL_BITS] <= w_col_out[g];
                    end
                    r_col <= r_col + COL_STEP;
                    if (r_col == LAST_COL) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign outstate  = r_st;

endmodule

// File: tb/tb_inv_round_tail.sv
// Directed and random checks of inv_round_tail against a bit-serial GF(2^8)
// reference of AddRoundKey + InvMixColumns.
module tb_inv_round_tail;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         skip_mix;
    logic         out_ready;
    logic [127:0] instate;
    logic [127:0] round_key;

    logic         in_ready,  out_valid;
    logic [127:0] outstate;
    logic         in_ready2, out_valid2;
    logic [127:0] outstate2;
    logic         in_ready4, out_valid4;
    logic [127:0] outstate4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inv_round_tail #(.COLS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instate(instate), .round_key(round_key), .skip_mix(skip_mix),
        .out_valid(out_valid), .out_ready(out_ready), .outstate(outstate)
    );

    inv_round_tail #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .instate(instate), .round_key(round_key), .skip_mix(skip_mix),
        .out_valid(out_valid2), .out_ready(1'b1), .outstate(outstate2)
    );

    inv_round_tail #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .instate(instate), .round_key(round_key), .skip_mix(skip_mix),
        .out_valid(out_valid4), .out_ready(1'b1), .outstate(outstate4)
    );

    typedef struct {
        logic [127:0] s;
        logic [127:0] k;
        logic         skip;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic [127:0] k,
                                               input logic skip);
        logic [127:0] t;
        logic [127:0] r;
        logic [7:0]   a [4];
        t = s ^ k;
        if (skip) return t;
        r = t;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = t[32*c + 8*j +: 8];
            for (int j = 0; j < 4; j++) begin
                r[32*c + 8*j +: 8] = gmul(8'h0e, a[j]) ^ gmul(8'h0b, a[(j+1)%4])
                                   ^ gmul(8'h0d, a[(j+2)%4]) ^ gmul(8'h09, a[(j+3)%4]);
            end
        end
        return r;
    endfunction

    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        skip_mix  = 1'b0;
        instate   = '0;
        round_key = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one block, wait for acceptance, then count cycles to out_valid
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic skip,
                        output int lat);
        int guard;
        @(negedge clk);
        instate   = s;
        round_key = k;
        skip_mix  = skip;
        in_valid  = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat1, lat2, lat4;
        logic [127:0] d1, d2, d4;
        int bad;
        int beats;
        logic [127:0] rs, rk, rexp;
        logic rskip;
        int stall;

        // Known columns: 8e4da1bc->db135345, 9fdc589d->f20a225c, c6.. and 01.. fixed
        vecs[0] = '{128'h01010101_c6c6c6c6_9d58dc9f_bca14d8e, 128'h0, 1'b0,
                    128'h01010101_c6c6c6c6_5c220af2_455313db, 5};
        vecs[1] = '{128'hfefefefe_39393939_62a72360_435eb271, {128{1'b1}}, 1'b0,
                    128'h01010101_c6c6c6c6_5c220af2_455313db, 5};
        vecs[2] = '{128'h9d58dc9f_bca14d8e_c6c6c6c6_01010101, 128'h0, 1'b0,
                    128'h5c220af2_455313db_c6c6c6c6_01010101, 5};
        vecs[3] = '{128'h0123456789abcdef0123456789abcdef, {128{1'b1}}, 1'b1,
                    128'hfedcba9876543210fedcba9876543210, 1};
        vecs[4] = '{128'h01010101_c6c6c6c6_9d58dc9f_bca14d8e, 128'h0, 1'b1,
                    128'h01010101_c6c6c6c6_9d58dc9f_bca14d8e, 1};
        vecs[5] = '{128'h0, 128'h0, 1'b0, 128'h0, 5};

        do_reset();
        @(negedge clk);
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check128("reset_outstate", outstate, 128'h0);

        // Latency sweep across COLS_PER_CYCLE = 1, 2, 4
        instate   = vecs[0].s;
        round_key = vecs[0].k;
        skip_mix  = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat1 = 0; lat2 = 0; lat4 = 0;
        d1 = '0; d2 = '0; d4 = '0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (out_valid  && lat1 == 0) begin lat1 = cyc; d1 = outstate;  end
            if (out_valid2 && lat2 == 0) begin lat2 = cyc; d2 = outstate2; end
            if (out_valid4 && lat4 == 0) begin lat4 = cyc; d4 = outstate4; end
            @(posedge clk);
            #1;
        end
        check_int("sweep_lat_cpc1", lat1, 5);
        check_int("sweep_lat_cpc2", lat2, 3);
        check_int("sweep_lat_cpc4", lat4, 2);
        check128("sweep_data_cpc1", d1, vecs[0].exp);
        check128("sweep_data_cpc2", d2, vecs[0].exp);
        check128("sweep_data_cpc4", d4, vecs[0].exp);
        check_int("sweep_cpc2_idle", int'(in_ready2), 1);
        check_int("sweep_cpc4_idle", int'(in_ready4), 1);
        drain();

        // Table-driven directed vectors
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].s, vecs[i].k, vecs[i].skip, lat);
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check128($sformatf("vec%0d_data", i), outstate, vecs[i].exp);
            check_int($sformatf("vec%0d_in_ready_done", i), int'(in_ready), 0);
            drain();
            check_int($sformatf("vec%0d_out_valid_after", i), int'(out_valid), 0);
            check_int($sformatf("vec%0d_in_ready_after", i), int'(in_ready), 1);
        end

        // Backpressure: hold DONE for 10 cycles with a competing input offered
        send(vecs[0].s, vecs[0].k, 1'b0, lat);
        instate   = 128'hdeadbeef_00000000_12345678_cafef00d;
        round_key = 128'h0;
        skip_mix  = 1'b1;
        in_valid  = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (outstate !== vecs[0].exp || !out_valid || in_ready) bad++;
        end
        check_int("bp_hold_errors", bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) beats++;
        end
        out_ready = 1'b0;
        check_int("bp_beats", beats, 1);
        check_int("bp_in_ready_after", int'(in_ready), 1);

        // Reset on the second BUSY cycle
        @(negedge clk);
        instate   = vecs[0].s;
        round_key = vecs[0].k;
        skip_mix  = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_int("rst_mid_out_valid", int'(out_valid), 0);
        check128("rst_mid_outstate", outstate, 128'h0);
        check_int("rst_mid_in_ready", int'(in_ready), 1);
        send(vecs[2].s, vecs[2].k, vecs[2].skip, lat);
        check_int("post_rst_latency", lat, 5);
        check128("post_rst_data", outstate, vecs[2].exp);
        drain();

        // Random regression with random DONE stalls
        for (int n = 0; n < 1000; n++) begin
            rs    = {$urandom, $urandom, $urandom, $urandom};
            rk    = {$urandom, $urandom, $urandom, $urandom};
            rskip = 1'($urandom_range(0, 1));
            rexp  = ref_model(rs, rk, rskip);
            send(rs, rk, rskip, lat);
            check_int($sformatf("rand%0d_latency", n), lat, rskip ? 1 : 5);
            stall = $urandom_range(0, 3);
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            check128($sformatf("rand%0d_data", n), outstate, rexp);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
